// File: rtl/intack_sequencer.sv
// Host-side 8086-style interrupt acknowledge sequencer: two active-low INTA pulses,
// vector capture on the second pulse, valid/ack hand-off and a completed-cycle counter.
module intack_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INT,
  input  logic       EN,
  input  logic [7:0] DBus,
  output logic       INTA,
  output logic [7:0] VEC,
  output logic       VEC_VALID,
  input  logic       VEC_ACK,
  output logic       BUSY,
  output logic [7:0] ACK_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    GAP,
    P2,
    HOLD
  } state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] phase, phase_nx;
  logic       int_s1, int_s2;
  logic       inta_nx;
  logic       capture;
  logic       release_vec;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      phase <= '0;
      INTA  <= 1'b1;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      INTA  <= inta_nx;
    end
  end

  // Phase counter counts down to zero; every state entry reloads it.
  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    capture     = 1'b0;
    release_vec = 1'b0;
    case (state)
      IDLE: begin
        if (int_s2 && EN) begin
          state_nx = P1;
          phase_nx = PULSE_LOAD;
        end
      end
      P1: begin
        if (phase == '0) begin
          state_nx = GAP;
          phase_nx = GAP_LOAD;
        end else begin
          phase_nx = phase - 4'd1;
        end
      end
      GAP: begin
        if (phase == '0) begin
          state_nx = P2;
          phase_nx = PULSE_LOAD;
        end else begin
          phase_nx = phase - 4'd1;
        end
      end
      P2: begin
        if (phase == '0) begin
          state_nx = HOLD;
          phase_nx = '0;
          capture  = 1'b1;
        end else begin
          phase_nx = phase - 4'd1;
        end
      end
      HOLD: begin
        if (VEC_ACK && VEC_VALID) begin
          state_nx    = IDLE;
          phase_nx    = '0;
          release_vec = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase
    inta_nx = !((state_nx == P1) || (state_nx == P2));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VEC       <= '0;
      VEC_VALID <= 1'b0;
      ACK_CNT   <= '0;
    end else if (capture) begin
      VEC       <= DBus;
      VEC_VALID <= 1'b1;
      ACK_CNT   <= ACK_CNT + 8'd1;
    end else if (release_vec) begin
      VEC_VALID <= 1'b0;
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_intack_sequencer.sv
// Scoreboarded random bench for intack_sequencer: stimulus queues expected vectors/counts,
// an independent monitor pops them when VEC_VALID rises and checks VEC stays stable.
module tb_intack_sequencer;

  localparam int PULSE = 2;
  localparam int GAP   = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       INT;
  logic       EN;
  logic [7:0] DBus;
  logic       INTA;
  logic [7:0] VEC;
  logic       VEC_VALID;
  logic       VEC_ACK;
  logic       BUSY;
  logic [7:0] ACK_CNT;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  typedef struct {
    logic [7:0] vec;
    logic [7:0] cnt;
  } exp_t;
  exp_t q[$];

  intack_sequencer #(
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .INT      (INT),
    .EN       (EN),
    .DBus     (DBus),
    .INTA     (INTA),
    .VEC      (VEC),
    .VEC_VALID(VEC_VALID),
    .VEC_ACK  (VEC_ACK),
    .BUSY     (BUSY),
    .ACK_CNT  (ACK_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_seq(input logic [7:0] v);
    exp_t e;
    n_done++;
    e.vec = v;
    e.cnt = 8'(n_done);
    q.push_back(e);
  endtask

  // Counts rising edges until INTA reaches lvl (sampled 1 time unit after each edge).
  task automatic wait_inta(input logic lvl, output int k);
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (INTA !== lvl && k < 100);
    check("inta_reach", INTA, lvl);
  endtask

  task automatic start_seq(input logic [7:0] v);
    int k;
    @(negedge CLK);
    INT = 1'b1;
    EN  = 1'b1;
    expect_seq(v);
    wait_inta(1'b0, k);
    check("int_to_inta_latency", k, 3);
  endtask

  // Entered just after the first INTA fall; returns just after VEC_VALID rises.
  task automatic body(input logic [7:0] v, input bit drop_in_gap, input bit keep_int,
                      input bit drop_en);
    int k;
    if (drop_en) EN = 1'b0;
    DBus = 8'($urandom);
    wait_inta(1'b1, k);
    check("p1_len", k, PULSE);
    if (drop_in_gap) INT = 1'b0;
    wait_inta(1'b0, k);
    check("gap_len", k, GAP);
    DBus = v;
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (!VEC_VALID && k < 100);
    check("p2_len", k, PULSE);
    check("inta_hold", INTA, 1'b1);
    check("busy_hold", BUSY, 1'b1);
    DBus = 8'($urandom);
    if (!keep_int) INT = 1'b0;
  endtask

  task automatic ack_it(input int w);
    repeat (w) @(posedge CLK);
    @(negedge CLK);
    VEC_ACK = 1'b1;
    @(posedge CLK);
    #1;
    VEC_ACK = 1'b0;
    check("valid_after_ack", VEC_VALID, 1'b0);
    check("busy_after_ack", BUSY, 1'b0);
    check("inta_after_ack", INTA, 1'b1);
  endtask

  // Monitor: decoupled from stimulus, samples 2 time units after each rising edge.
  initial begin
    bit         prev;
    logic [7:0] held;
    exp_t       e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (RST) begin
        prev = 1'b0;
      end else begin
        if (VEC_VALID && !prev) begin
          check("vec_expected", q.size() > 0, 1'b1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("vec", VEC, e.vec);
            check("ack_cnt", ACK_CNT, e.cnt);
          end
          held = VEC;
        end else if (VEC_VALID) begin
          check("vec_stable", VEC, held);
        end
        prev = VEC_VALID;
      end
    end
  end

  initial begin
    int         k;
    logic [7:0] v, v2;
    RST     = 1'b1;
    INT     = 1'b0;
    EN      = 1'b0;
    VEC_ACK = 1'b0;
    DBus    = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      check("idle_inta", INTA, 1'b1);
      check("idle_valid", VEC_VALID, 1'b0);
      check("idle_busy", BUSY, 1'b0);
      check("idle_cnt", ACK_CNT, 8'h00);
    end
    check("reset_vec", VEC, 8'h00);

    // Basic acknowledge: INTA low 3..5, high 5..7, low 7..9, ack at edge 11
    start_seq(8'h92);
    body(8'h92, 1'b0, 1'b0, 1'b0);
    check("basic_cnt", ACK_CNT, 8'd1);
    ack_it(1);

    // Masked by EN
    @(negedge CLK);
    EN  = 1'b0;
    INT = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      check("masked_inta", INTA, 1'b1);
      check("masked_busy", BUSY, 1'b0);
    end
    @(negedge CLK);
    EN = 1'b1;
    expect_seq(8'h5a);
    wait_inta(1'b0, k);
    check("en_to_inta_latency", k, 1);
    body(8'h5a, 1'b0, 1'b0, 1'b0);
    ack_it(2);

    // INT drop during GAP still completes the second pulse
    start_seq(8'h97);
    body(8'h97, 1'b1, 1'b0, 1'b0);
    ack_it(1);

    // Held ack with INT still high: exactly one sequence until ack
    v  = 8'($urandom);
    v2 = 8'($urandom);
    start_seq(v);
    body(v, 1'b0, 1'b1, 1'b0);
    expect_seq(v2);
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      check("held_valid", VEC_VALID, 1'b1);
      check("held_inta", INTA, 1'b1);
    end
    @(negedge CLK);
    VEC_ACK = 1'b1;
    @(posedge CLK);
    #1;
    VEC_ACK = 1'b0;
    check("held_release_valid", VEC_VALID, 1'b0);
    check("held_release_inta", INTA, 1'b1);
    wait_inta(1'b0, k);
    check("rearm_latency", k, 1);
    body(v2, 1'b0, 1'b0, 1'b0);
    ack_it(1);

    // Random sequences, including EN dropping after the decision
    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom);
      start_seq(v);
      body(v, 1'($urandom), 1'b0, 1'($urandom));
      ack_it(int'($urandom_range(1, 5)));
    end

    // Asynchronous reset in the middle of P2
    @(negedge CLK);
    INT = 1'b1;
    EN  = 1'b1;
    wait_inta(1'b0, k);
    wait_inta(1'b1, k);
    wait_inta(1'b0, k);
    check("p2_before_reset", INTA, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("rst_inta", INTA, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_valid", VEC_VALID, 1'b0);
    check("rst_cnt", ACK_CNT, 8'h00);
    check("rst_vec", VEC, 8'h00);
    INT    = 1'b0;
    n_done = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      check("post_rst_inta", INTA, 1'b1);
      check("post_rst_busy", BUSY, 1'b0);
    end

    // 256 sequences wrap ACK_CNT back to zero
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      start_seq(v);
      body(v, 1'($urandom), 1'b0, 1'($urandom));
      ack_it(int'($urandom_range(1, 3)));
    end
    check("ack_cnt_wrap", ACK_CNT, 32'(8'(n_done)));

    repeat (5) @(posedge CLK);
    #3;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
